config_chain_loader: RTL and testbench



---
 rtl/config_chain_loader.sv | 119 +++++++++++
 tb/tb_config_chain_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader.sv
// Serial configuration chain loader: streams config words LSB-first into the chain head
// and returns the bits falling out of the chain tail as readback words.
module config_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 20
) (
    input  logic              shift_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              shift_en,
    output logic              shift_o,
    input  logic              shift_i,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  LAST_SLOT = WB_W'(WORD_W - 1);

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DRAIN, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  bcnt;
    logic [CNT_W-1:0]  rem;
    logic [WB_W-1:0]   wbits;
    logic [WB_W-1:0]   acnt;
    logic [WORD_W-1:0] tx_sr;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_next;
    logic              word_full;
    logic              stall;

    assign rem       = CNT_W'(CHAIN_LEN) - bcnt;
    // The next capture closes a readback word either on a full word or on the final chain bit.
    assign word_full = (acnt == LAST_SLOT) || (bcnt == LAST_BIT);
    assign stall     = rb_valid && word_full;
    assign acc_next  = acc | (WORD_W'(shift_i) << acnt);

    // All outputs decode registered state only, so no input reaches an output combinationally.
    assign shift_en  = (state == SHIFT) && !stall;
    assign shift_o   = tx_sr[0];
    assign cfg_ready = (state == FETCH);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge shift_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bcnt     <= '0;
            wbits    <= '0;
            acnt     <= '0;
            tx_sr    <= '0;
            acc      <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            if (rb_valid && rb_ready) begin
                rb_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        bcnt  <= '0;
                        acnt  <= '0;
                        acc   <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (cfg_valid) begin
                        tx_sr <= cfg_data;
                        wbits <= (32'(rem) >= WORD_W) ? WB_W'(WORD_W) : WB_W'(rem);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!stall) begin
                        tx_sr <= tx_sr >> 1;
                        wbits <= wbits - 1'b1;
                        bcnt  <= bcnt + 1'b1;
                        if (word_full) begin
                            rb_data  <= acc_next;
                            rb_valid <= 1'b1;
                            acc      <= '0;
                            acnt     <= '0;
                        end else begin
                            acc  <= acc_next;
                            acnt <= acnt + 1'b1;
                        end
                        // Final chain bit wins over end-of-word; leftover word bits are dropped.
                        if (bcnt == LAST_BIT) begin
                            state <= DRAIN;
                        end else if (wbits == WB_W'(1)) begin
                            state <= FETCH;
                        end
                    end
                end
                DRAIN: begin
                    if (!rb_valid) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: two instances (20-bit and 16-bit chains) driven through a
// behavioural chain model, with expected stream contents computed arithmetically.
module tb_config_chain_loader;
    localparam int W = 8;

    logic         shift_clk = 1'b0;
    logic         rst_n     = 1'b0;
    logic         start     = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         rb_ready  = 1'b0;
    logic         sel       = 1'b0;
    logic [W-1:0] cfg_data  = '0;
    logic         shift_i;

    logic         cfg_ready_a, shift_en_a, shift_o_a, rb_valid_a, busy_a, done_a;
    logic [W-1:0] rb_data_a;
    logic         cfg_ready_b, shift_en_b, shift_o_b, rb_valid_b, busy_b, done_b;
    logic [W-1:0] rb_data_b;
    logic         cfg_ready, shift_en, shift_o, rb_valid, busy, done;
    logic [W-1:0] rb_data;

    int           chain_len = 20;
    logic [31:0]  chain     = '0;

    assign shift_i   = chain[0];
    assign cfg_ready = sel ? cfg_ready_b : cfg_ready_a;
    assign shift_en  = sel ? shift_en_b  : shift_en_a;
    assign shift_o   = sel ? shift_o_b   : shift_o_a;
    assign rb_valid  = sel ? rb_valid_b  : rb_valid_a;
    assign rb_data   = sel ? rb_data_b   : rb_data_a;
    assign busy      = sel ? busy_b      : busy_a;
    assign done      = sel ? done_b      : done_a;

    config_chain_loader #(.WORD_W(W), .CHAIN_LEN(20)) dut_a (
        .shift_clk(shift_clk), .rst_n(rst_n), .start(start && !sel),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a),
        .shift_en(shift_en_a), .shift_o(shift_o_a), .shift_i(shift_i),
        .rb_data(rb_data_a), .rb_valid(rb_valid_a), .rb_ready(rb_ready),
        .busy(busy_a), .done(done_a)
    );

    config_chain_loader #(.WORD_W(W), .CHAIN_LEN(16)) dut_b (
        .shift_clk(shift_clk), .rst_n(rst_n), .start(start && sel),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b),
        .shift_en(shift_en_b), .shift_o(shift_o_b), .shift_i(shift_i),
        .rb_data(rb_data_b), .rb_valid(rb_valid_b), .rb_ready(rb_ready),
        .busy(busy_b), .done(done_b)
    );

    always #5 shift_clk = ~shift_clk;

    int   checks = 0;
    int   errors = 0;
    int   n_shift, n_fetch, n_done, n_gap;
    int   en_fetch_viol, gap_viol, busy_viol;
    bit   pend, pend_bit, cfg_acc, prev_done, prev_gap;
    logic prev_so;
    logic sent_q[$];
    logic [W-1:0] rb_q[$];
    logic [W-1:0] words[4];
    logic [63:0]  prior;

    // Monitor samples on the falling edge; the chain model shifts just after the rising edge.
    always begin
        @(negedge shift_clk);
        pend     = shift_en;
        pend_bit = shift_o;
        cfg_acc  = cfg_valid && cfg_ready;
        if (shift_en) begin
            sent_q.push_back(shift_o);
            n_shift++;
        end
        if (cfg_ready) begin
            n_fetch++;
            if (shift_en) en_fetch_viol++;
        end
        if (cfg_ready && !cfg_valid) begin
            n_gap++;
            if (prev_gap && shift_o !== prev_so) gap_viol++;
        end
        prev_gap = cfg_ready && !cfg_valid;
        prev_so  = shift_o;
        if (rb_valid && rb_ready) rb_q.push_back(rb_data);
        if (prev_done && busy) busy_viol++;
        if (done) n_done++;
        prev_done = done;
        @(posedge shift_clk);
        #1;
        if (pend) begin
            chain = chain >> 1;
            chain[chain_len-1] = pend_bit;
        end
    end

    task automatic tick();
        @(posedge shift_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_mon();
        sent_q.delete();
        rb_q.delete();
        n_shift = 0; n_fetch = 0; n_done = 0; n_gap = 0;
        en_fetch_viol = 0; gap_viol = 0; busy_viol = 0;
        prev_gap = 1'b0; prev_done = 1'b0;
    endtask

    task automatic rand_words();
        for (int k = 0; k < 4; k++) words[k] = W'($urandom);
    endtask

    // rb_mode: 0 = always ready, 1 = not ready until cycle 'hold', 2 = random.
    task automatic run_load(input int gap, input int rb_mode, input int hold,
                            input int abort_at, input bit check_rb);
        int          len, nw, idx, cyc;
        bit          dup;
        logic [63:0] exp_sent, got_sent;
        len = chain_len;
        nw  = (len + W - 1) / W;
        clear_mon();
        idx = 0; cyc = 0; dup = 1'b0;
        cfg_data  = words[0];
        cfg_valid = 1'b1;
        rb_ready  = (rb_mode != 1);
        start     = 1'b1;
        while (n_done == 0 && cyc < 400) begin
            tick();
            cyc++;
            start = 1'b0;
            if (cfg_acc) idx++;
            cfg_valid = (idx < nw) && !(idx == 1 && n_gap < gap);
            cfg_data  = (idx < nw) ? words[idx] : '0;
            case (rb_mode)
                0:       rb_ready = 1'b1;
                1:       rb_ready = (cyc >= hold);
                default: rb_ready = 1'($urandom_range(0, 1));
            endcase
            if (rb_mode == 1 && cyc == hold - 1) begin
                chk("bp_shift_count", 64'(n_shift), 64'd15);
                chk("bp_shift_en", 64'(shift_en), 64'd0);
                chk("bp_rb_held", 64'(rb_data), prior & 64'hFF);
            end
            if (abort_at > 0) begin
                if (n_shift == 5 && !dup) begin
                    start = 1'b1;
                    dup   = 1'b1;
                end
                if (n_shift >= abort_at) begin
                    chk("abort_busy_before", 64'(busy), 64'd1);
                    rst_n = 1'b0;
                    #2;
                    chk("abort_shift_en", 64'(shift_en), 64'd0);
                    chk("abort_cfg_ready", 64'(cfg_ready), 64'd0);
                    chk("abort_rb_valid", 64'(rb_valid), 64'd0);
                    cfg_valid = 1'b0;
                    return;
                end
            end
        end
        cfg_valid = 1'b0;
        tick();
        tick();
        exp_sent = '0;
        for (int k = 0; k < nw; k++) exp_sent |= 64'(words[k]) << (W * k);
        exp_sent &= (64'd1 << len) - 64'd1;
        got_sent = '0;
        for (int i = 0; i < sent_q.size(); i++) got_sent |= 64'(sent_q[i]) << i;
        chk("no_timeout", 64'(cyc < 400), 64'd1);
        chk("shift_count", 64'(n_shift), 64'(len));
        chk("shift_bits", got_sent, exp_sent);
        chk("done_pulses", 64'(n_done), 64'd1);
        chk("busy_after_done", 64'(busy_viol), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("en_in_fetch", 64'(en_fetch_viol), 64'd0);
        chk("fetch_cycles", 64'(n_fetch), 64'(nw + gap));
        chk("gap_cycles", 64'(n_gap), 64'(gap));
        chk("gap_shift_o", 64'(gap_viol), 64'd0);
        if (check_rb) begin
            chk("rb_count", 64'(rb_q.size()), 64'(nw));
            for (int k = 0; k < rb_q.size() && k < nw; k++)
                chk($sformatf("rb_word%0d", k), 64'(rb_q[k]), (prior >> (W * k)) & 64'hFF);
        end
        prior = exp_sent;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        chk("rst_shift_en", 64'(shift_en), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_cfg_ready", 64'(cfg_ready), 64'd0);
        chk("idle_shift_en", 64'(shift_en), 64'd0);
        chk("idle_shift_o", 64'(shift_o), 64'd0);
        chk("idle_rb_valid", 64'(rb_valid), 64'd0);
        chk("idle_rb_data", 64'(rb_data), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);

        // Basic load over a chain preloaded with 0xABCDE (bit 0 at the tail).
        chain_len = 20;
        chain     = 32'h000ABCDE;
        prior     = 64'hABCDE;
        words     = '{8'hA5, 8'h3C, 8'h0F, 8'h00};
        run_load(0, 0, 0, 0, 1'b1);
        chk("basic_first_bits", 64'(sent_q.size()), 64'd20);

        // Immediate second load reads back 0xA5, 0x3C, 0x0F.
        rand_words();
        run_load(0, 0, 0, 0, 1'b1);

        // Readback backpressure, then config gap, then random rb_ready.
        rand_words();
        run_load(0, 1, 60, 0, 1'b1);
        rand_words();
        run_load(5, 0, 0, 0, 1'b1);
        rand_words();
        run_load(0, 2, 0, 0, 1'b1);

        // Abort mid-load, then two full loads (the second verifies the first).
        rand_words();
        run_load(0, 0, 0, 10, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("post_abort_busy", 64'(busy), 64'd0);
        rand_words();
        run_load(0, 0, 0, 0, 1'b0);
        rand_words();
        run_load(0, 2, 0, 0, 1'b1);

        // Chain length an exact multiple of the word width.
        sel       = 1'b1;
        chain_len = 16;
        chain     = 32'h0000BEEF;
        prior     = 64'hBEEF;
        tick();
        rand_words();
        run_load(0, 0, 0, 0, 1'b1);
        rand_words();
        run_load(0, 2, 0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
